// File: rtl/snes_pkg.sv
// Shared definitions for the SNES controller reader family.
// Contents: the frame FSM state type, the button bit positions within a
// port's button word (bit 0 = B ... bit 11 = R), and the default timing for
// a 25 MHz system clock.
package snes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam int unsigned BTN_B      = 0;
  localparam int unsigned BTN_Y      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;
  localparam int unsigned BTN_A      = 8;
  localparam int unsigned BTN_X      = 9;
  localparam int unsigned BTN_L      = 10;
  localparam int unsigned BTN_R      = 11;

  localparam int unsigned DEF_N_BITS    = 16;
  localparam int unsigned DEF_N_BTN     = 12;
  localparam int unsigned DEF_LATCH_CYC = 300;     // 12 us
  localparam int unsigned DEF_HALF_CYC  = 150;     // 6 us
  localparam int unsigned DEF_POLL_CYC  = 416667;  // 60 Hz

endpackage

// File: rtl/snes_port_capture.sv
// Per-port capture for one SNES pad.
// Synchronises the pad's serial data line, stores each sampled bit at the
// index supplied by the shared frame FSM, and on the done strobe publishes
// the button word, one-cycle pressed/released masks and the presence flag.
// Ports:
//   clk_25M, rst_n   - clock, asynchronous active-low reset
//   data_in          - raw serial data from the pad
//   sample_en        - store the synchronised bit into raw[bit_idx]
//   bit_idx          - bit position of the current serial bit
//   done_stb         - end of frame: evaluate ID bits and update outputs
//   btn              - button state, 1 = pressed
//   pressed/released - one-cycle event masks
//   present          - ID bits matched on the last frame
module snes_port_capture
  import snes_pkg::*;
#(
  parameter int unsigned N_BITS = DEF_N_BITS,
  parameter int unsigned N_BTN  = DEF_N_BTN,
  parameter int unsigned IDX_W  = 4,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter logic [N_BITS-N_BTN-1:0] ID_PATTERN = '1
) (
  input  logic             clk_25M,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic             sample_en,
  input  logic [IDX_W-1:0] bit_idx,
  input  logic             done_stb,
  output logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] released,
  output logic             present
);

  logic [1:0]        sync_q;
  logic [N_BITS-1:0] raw_q;
  logic              id_ok;
  logic [N_BTN-1:0]  new_btn;

  always_comb begin
    id_ok   = (raw_q[N_BITS-1:N_BTN] == ID_PATTERN);
    new_btn = ACTIVE_LOW ? ~raw_q[N_BTN-1:0] : raw_q[N_BTN-1:0];
  end

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      raw_q    <= '0;
      btn      <= '0;
      pressed  <= '0;
      released <= '0;
      present  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], data_in};
      if (sample_en) begin
        raw_q[bit_idx] <= sync_q[1];
      end
      if (done_stb) begin
        present <= id_ok;
        if (id_ok) begin
          btn      <= new_btn;
          pressed  <= new_btn & ~btn;
          released <= ~new_btn & btn;
        end else begin
          // Unplugged pad: everything that was held reads as released.
          btn      <= '0;
          pressed  <= '0;
          released <= btn;
        end
      end else begin
        pressed  <= '0;
        released <= '0;
      end
    end
  end

endmodule

// File: rtl/snes_multi_reader.sv
// Multi-port SNES controller reader.
// All pads share one latch and one serial clock; each has its own data line.
// A frame is: latch pulse, then N_BITS serial clock periods (low then high),
// then a single DONE cycle in which every port's outputs update together.
// Ports:
//   clk_25M, rst_n  - clock, asynchronous active-low reset
//   enable          - auto-poll every POLL_CYC cycles
//   poll_req        - one-cycle request for an immediate frame
//   SNES_Data       - serial data, one bit per port
//   SNES_Latch      - shared latch, SNES_clk_1 - shared serial clock (idle high)
//   btn_output      - button state, port p at [p*N_BTN +: N_BTN], 1 = pressed
//   btn_pressed     - one-cycle 0->1 mask, btn_released - one-cycle 1->0 mask
//   present         - per-port ID check result from the last frame
//   frame_valid     - strobe during the cycle the outputs are fresh
//   busy            - a frame is in progress
module snes_multi_reader
  import snes_pkg::*;
#(
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned N_BITS    = DEF_N_BITS,
  parameter int unsigned N_BTN     = DEF_N_BTN,
  parameter int unsigned LATCH_CYC = DEF_LATCH_CYC,
  parameter int unsigned HALF_CYC  = DEF_HALF_CYC,
  parameter int unsigned POLL_CYC  = DEF_POLL_CYC,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter logic [N_BITS-N_BTN-1:0] ID_PATTERN = 4'b1111
) (
  input  logic                     clk_25M,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     poll_req,
  input  logic [N_PORTS-1:0]       SNES_Data,
  output logic                     SNES_Latch,
  output logic                     SNES_clk_1,
  output logic [N_PORTS*N_BTN-1:0] btn_output,
  output logic [N_PORTS*N_BTN-1:0] btn_pressed,
  output logic [N_PORTS*N_BTN-1:0] btn_released,
  output logic [N_PORTS-1:0]       present,
  output logic                     frame_valid,
  output logic                     busy
);

  localparam int unsigned CYC_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int unsigned CNT_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int unsigned POLL_W  = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam int unsigned IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cyc_cnt;
  logic [IDX_W-1:0]    bit_idx;
  logic [POLL_W-1:0]   poll_cnt;
  logic                pending;
  logic                poll_wrap;
  logic                start;
  logic                half_last;
  logic                sample_en;
  logic                done_stb;

  always_comb begin
    poll_wrap = enable && (poll_cnt == POLL_W'(POLL_CYC - 1));
    // A request coinciding with the wrap is a single start.
    start     = poll_wrap || poll_req;
    half_last = (cyc_cnt == CNT_W'(HALF_CYC - 1));
  end

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      bit_idx  <= '0;
      poll_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      state <= state_nx;

      if (!enable || poll_wrap) begin
        poll_cnt <= '0;
      end else begin
        poll_cnt <= poll_cnt + 1'b1;
      end

      // In IDLE any held request is consumed by the start it triggers.
      if (state == IDLE) begin
        pending <= 1'b0;
      end else if (start) begin
        pending <= 1'b1;
      end

      if (state_nx != state) begin
        cyc_cnt <= '0;
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end

      if (state == LATCH) begin
        bit_idx <= '0;
      end else if (state == HIGH && state_nx == LOW) begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    sample_en = 1'b0;
    done_stb  = 1'b0;
    case (state)
      IDLE: begin
        if (start || pending) state_nx = LATCH;
      end
      LATCH: begin
        if (cyc_cnt == CNT_W'(LATCH_CYC - 1)) state_nx = LOW;
      end
      LOW: begin
        if (half_last) begin
          sample_en = 1'b1;
          state_nx  = HIGH;
        end
      end
      HIGH: begin
        if (half_last) begin
          if (bit_idx == IDX_W'(N_BITS - 1)) begin
            done_stb = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = LOW;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture registers load on the edge into DONE, so the fresh outputs and
  // frame_valid coincide during the DONE cycle.
  assign SNES_Latch  = (state == LATCH);
  assign SNES_clk_1  = (state != LOW);
  assign busy        = (state != IDLE);
  assign frame_valid = (state == DONE);

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    snes_port_capture #(
      .N_BITS     (N_BITS),
      .N_BTN      (N_BTN),
      .IDX_W      (IDX_W),
      .ACTIVE_LOW (ACTIVE_LOW),
      .ID_PATTERN (ID_PATTERN)
    ) u_capture (
      .clk_25M   (clk_25M),
      .rst_n     (rst_n),
      .data_in   (SNES_Data[p]),
      .sample_en (sample_en),
      .bit_idx   (bit_idx),
      .done_stb  (done_stb),
      .btn       (btn_output[p*N_BTN +: N_BTN]),
      .pressed   (btn_pressed[p*N_BTN +: N_BTN]),
      .released  (btn_released[p*N_BTN +: N_BTN]),
      .present   (present[p])
    );
  end

endmodule

// File: tb/tb_snes_multi_reader.sv
module tb_snes_multi_reader;

  logic        clk_25M = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        poll_req;
  logic [1:0]  snes_data;
  logic        snes_latch;
  logic        snes_clk;
  logic [23:0] btn_output;
  logic [23:0] btn_pressed;
  logic [23:0] btn_released;
  logic [1:0]  present;
  logic        frame_valid;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  snes_multi_reader #(
    .N_PORTS   (2),
    .LATCH_CYC (4),
    .HALF_CYC  (2),
    .POLL_CYC  (200)
  ) dut (
    .clk_25M      (clk_25M),
    .rst_n        (rst_n),
    .enable       (enable),
    .poll_req     (poll_req),
    .SNES_Data    (snes_data),
    .SNES_Latch   (snes_latch),
    .SNES_clk_1   (snes_clk),
    .btn_output   (btn_output),
    .btn_pressed  (btn_pressed),
    .btn_released (btn_released),
    .present      (present),
    .frame_valid  (frame_valid),
    .busy         (busy)
  );

  always #5 clk_25M = ~clk_25M;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pad model: latch reloads the shift position, each rising serial clock
  // outside the latch advances it; bit 0 is on the line right after latch.
  logic [15:0] pad_raw [2];
  int unsigned pad_idx = 0;

  always @(posedge snes_latch or posedge snes_clk) begin
    if (snes_latch) pad_idx = 0;
    else pad_idx = pad_idx + 1;
  end

  always_comb begin
    snes_data = '0;
    for (int p = 0; p < 2; p++)
      snes_data[p] = (pad_idx < 16) ? pad_raw[p][pad_idx[3:0]] : 1'b0;
  end

  // Reference model: per-frame button semantics applied whenever a frame
  // completes, using the pattern the pads were serving.
  logic [11:0] m_btn [2];
  logic [1:0]  m_pres;
  logic        prev_fv;

  always @(negedge clk_25M) begin
    logic [11:0] nb, pr, rl;
    logic        pres;
    if (!rst_n) begin
      m_btn[0] = '0;
      m_btn[1] = '0;
      m_pres   = '0;
      prev_fv  = 1'b0;
    end else begin
      if (frame_valid) begin
        for (int p = 0; p < 2; p++) begin
          pres = (pad_raw[p][15:12] == 4'hF);
          if (pres) begin
            nb = ~pad_raw[p][11:0];
            pr = nb & ~m_btn[p];
            rl = m_btn[p] & ~nb;
          end else begin
            nb = '0;
            pr = '0;
            rl = m_btn[p];
          end
          chk("model_btn", btn_output[p*12 +: 12], nb);
          chk("model_pressed", btn_pressed[p*12 +: 12], pr);
          chk("model_released", btn_released[p*12 +: 12], rl);
          chk("model_present", present[p], pres);
          m_btn[p]  = nb;
          m_pres[p] = pres;
        end
      end else if (prev_fv) begin
        chk("events_one_cycle", {btn_pressed, btn_released}, '0);
      end
      prev_fv = frame_valid;
    end
  end

  // One polled frame: reports strobe latency and waveform counts, and the
  // outputs seen during the frame_valid cycle.
  task automatic run_frame(input logic [15:0] r0, input logic [15:0] r1,
                           output int fv_cyc, output int lat, output int lows,
                           output int falls, output logic [23:0] b,
                           output logic [23:0] pr, output logic [23:0] rl,
                           output logic [1:0] pres);
    logic prev_clk;
    pad_raw[0] = r0;
    pad_raw[1] = r1;
    fv_cyc = 0; lat = 0; lows = 0; falls = 0;
    b = '0; pr = '0; rl = '0; pres = '0;
    prev_clk = 1'b1;
    poll_req = 1'b1;
    @(negedge clk_25M);
    poll_req = 1'b0;
    for (int n = 1; n < 200; n++) begin
      if (snes_latch) lat++;
      if (!snes_clk) lows++;
      if (!snes_clk && prev_clk) falls++;
      prev_clk = snes_clk;
      if (frame_valid) begin
        fv_cyc = n;
        b = btn_output; pr = btn_pressed; rl = btn_released; pres = present;
        break;
      end
      @(negedge clk_25M);
    end
    repeat (3) @(negedge clk_25M);
  endtask

  typedef struct {
    logic [15:0] raw0;
    logic [15:0] raw1;
    logic [23:0] btn;
    logic [23:0] pr;
    logic [23:0] rl;
    logic [1:0]  pres;
  } vec_t;

  vec_t tab [5];

  initial begin
    int fv_cyc, lat, lows, falls, per, hi, fvs, t_fv, t_rise;
    logic [23:0] b, pr, rl;
    logic [1:0]  pres;
    logic        found, prev_busy;
    logic [15:0] r0, r1;

    // Raw words are bit 0 first on the wire; port 0 bits 11:0 of the first
    // row are 0,1,1,0,1,1,0,0,0,1,0,1 -> inverted 12'h5C9.
    tab[0] = '{16'hFA36, 16'h0000, {12'h000, 12'h5C9}, {12'h000, 12'h5C9}, 24'h0, 2'b01};
    tab[1] = '{16'hFB36, 16'h0000, {12'h000, 12'h4C9}, 24'h0, {12'h000, 12'h100}, 2'b01};
    tab[2] = '{16'hFA37, 16'h0000, {12'h000, 12'h5C8}, {12'h000, 12'h100}, {12'h000, 12'h001}, 2'b01};
    tab[3] = '{16'h0A37, 16'h0000, 24'h0, 24'h0, {12'h000, 12'h5C8}, 2'b00};
    tab[4] = '{16'hFFFF, 16'hF000, {12'hFFF, 12'h000}, {12'hFFF, 12'h000}, 24'h0, 2'b11};

    rst_n = 1'b0; enable = 1'b0; poll_req = 1'b0;
    pad_raw[0] = '0; pad_raw[1] = '0;
    repeat (3) @(negedge clk_25M);
    chk("reset_btn", {btn_output, btn_pressed, btn_released}, '0);
    chk("reset_present", present, 2'b00);
    chk("reset_ctrl", {frame_valid, busy, snes_latch, snes_clk}, 4'b0001);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_25M);

    for (int i = 0; i < 5; i++) begin
      run_frame(tab[i].raw0, tab[i].raw1, fv_cyc, lat, lows, falls, b, pr, rl, pres);
      chk("tab_fv_cycle", fv_cyc, 69);
      chk("tab_latch_cycles", lat, 4);
      chk("tab_clk_low_cycles", lows, 32);
      chk("tab_clk_pulses", falls, 16);
      chk("tab_btn", b, tab[i].btn);
      chk("tab_pressed", pr, tab[i].pr);
      chk("tab_released", rl, tab[i].rl);
      chk("tab_present", pres, tab[i].pres);
    end

    for (int i = 0; i < 20; i++) begin
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      if ($urandom_range(0, 3) != 0) r0[15:12] = 4'hF;
      if ($urandom_range(0, 3) != 0) r1[15:12] = 4'hF;
      run_frame(r0, r1, fv_cyc, lat, lows, falls, b, pr, rl, pres);
      chk("rand_fv_cycle", fv_cyc, 69);
    end

    // Auto-poll period and busy duty.
    enable = 1'b1;
    prev_busy = busy;
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk_25M);
      if (busy && !prev_busy) found = 1'b1;
      prev_busy = busy;
    end
    chk("auto_first_start", found, 1'b1);
    for (int k = 0; k < 2; k++) begin
      per = 0; hi = 0; found = 1'b0;
      for (int n = 0; n < 400 && !found; n++) begin
        if (busy) hi++;
        per++;
        @(negedge clk_25M);
        if (busy && !prev_busy) found = 1'b1;
        prev_busy = busy;
      end
      chk("auto_period", per, 200);
      chk("auto_busy_cycles", hi, 69);
    end

    // enable dropped mid-frame: that frame finishes, nothing follows.
    repeat (5) @(negedge clk_25M);
    enable = 1'b0;
    fvs = 0;
    for (int n = 0; n < 450; n++) begin
      if (frame_valid) fvs++;
      @(negedge clk_25M);
    end
    chk("enable_off_frames", fvs, 1);

    // Two requests during a busy frame: one queued, one dropped.
    fvs = 0; t_fv = -1; t_rise = -1; prev_busy = 1'b0;
    poll_req = 1'b1;
    @(negedge clk_25M);
    for (int n = 1; n < 300; n++) begin
      poll_req = (n == 10 || n == 30);
      if (frame_valid) begin
        fvs++;
        if (fvs == 1) t_fv = n;
      end
      if (busy && !prev_busy && fvs == 1 && t_rise < 0) t_rise = n;
      prev_busy = busy;
      @(negedge clk_25M);
    end
    poll_req = 1'b0;
    chk("pending_frames", fvs, 2);
    chk("pending_restart_gap", t_rise - t_fv, 2);

    // Reset during bit 7 of a frame with non-zero outputs.
    run_frame(16'hF000, 16'hF0F0, fv_cyc, lat, lows, falls, b, pr, rl, pres);
    chk("prereset_present", pres, 2'b11);
    poll_req = 1'b1;
    @(negedge clk_25M);
    poll_req = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (pad_idx == 7 && !snes_clk) found = 1'b1;
      else @(negedge clk_25M);
    end
    chk("reached_bit7", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_ctrl", {snes_clk, snes_latch, busy, frame_valid}, 4'b1000);
    chk("midreset_outputs", {btn_output, btn_pressed, btn_released, present}, '0);
    repeat (3) @(negedge clk_25M);
    rst_n = 1'b1;
    fvs = 0;
    for (int n = 0; n < 150; n++) begin
      if (frame_valid) fvs++;
      @(negedge clk_25M);
    end
    chk("midreset_no_frame", fvs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
